bf16_op_dispatch: RTL and testbench

Pipelined, flow-controlled dispatcher for the bfloat16 arithmetic units. Accepts operation requests over a valid/ready handshake and registers the operands into the adder or multiplier `op_intf` port. Captures each unit result after a configurable latency and returns results in request order through a credit-protected response FIFO. Adds subtraction, illegal-mode reporting and a sticky overflow status.

---
 rtl/data_type_pkg.sv | 34 +++
 rtl/op_intf.sv | 30 +++
 rtl/bf16_resp_fifo.sv | 45 ++++
 rtl/bf16_op_dispatch.sv | 147 ++++++++++++++
 tb/tb_bf16_op_dispatch.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_type_pkg.sv
// Shared types and constants for the bf16 arithmetic dispatch path.
package data_type_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int MODE_WIDTH = 2;

  localparam logic [MODE_WIDTH-1:0] MODE_ADD = 2'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_SUB = 2'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_MUL = 2'd2;

  typedef struct packed {
    logic                  illegal;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] data;
  } bf16_resp_t;

  typedef enum logic [1:0] {
    UNIT_NONE,
    UNIT_ADD,
    UNIT_MUL
  } unit_e;

  typedef struct packed {
    logic  valid;
    unit_e unit;
  } token_t;

  function automatic unit_e unit_of(input logic [MODE_WIDTH-1:0] op);
    case (op)
      MODE_ADD, MODE_SUB: return UNIT_ADD;
      MODE_MUL:           return UNIT_MUL;
      default:            return UNIT_NONE;
    endcase
  endfunction
endpackage

// File: rtl/op_intf.sv
// Operand/result port of a bf16 arithmetic unit.
interface op_intf #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
);
  logic                  op1_sign;
  logic [EXP_WIDTH-1:0]  op1_exp;
  logic [FRAC_WIDTH-1:0] op1_frac;
  logic                  op2_sign;
  logic [EXP_WIDTH-1:0]  op2_exp;
  logic [FRAC_WIDTH-1:0] op2_frac;
  logic                  op3_sign;
  logic [EXP_WIDTH-1:0]  op3_exp;
  logic [FRAC_WIDTH-1:0] op3_frac;
  logic                  overflow;

  modport bus_side (
    output op1_sign, op1_exp, op1_frac,
    output op2_sign, op2_exp, op2_frac,
    input  op3_sign, op3_exp, op3_frac,
    input  overflow
  );

  modport unit_side (
    input  op1_sign, op1_exp, op1_frac,
    input  op2_sign, op2_exp, op2_frac,
    output op3_sign, op3_exp, op3_frac,
    output overflow
  );
endinterface

// File: rtl/bf16_resp_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered count.
module bf16_resp_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr + AW'(1)) & MASK;
      if (rd_en) rd_ptr <= (rd_ptr + AW'(1)) & MASK;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/bf16_op_dispatch.sv
// Issues bf16 add/sub/mul requests to the arithmetic units and returns
// their results in request order through a credit-protected FIFO.
module bf16_op_dispatch
  import data_type_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7,
  parameter int UNIT_LAT   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [MODE_WIDTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0] in1_i,
  input  logic [DATA_WIDTH-1:0] in2_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] out_o,
  output logic                  overflow_o,
  output logic                  illegal_o,
  output logic                  ovf_sticky_o,
  input  logic                  ovf_clr_i,
  output logic                  busy_o,
  op_intf.bus_side              add_intf,
  op_intf.bus_side              mul_intf
);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int EM   = DATA_WIDTH - 2;
  localparam int LAST = UNIT_LAT;

  token_t                tok [LAST+1];
  logic [MODE_WIDTH-1:0] iss_op;
  logic [DATA_WIDTH-1:0] iss_a, iss_b, op_b;
  logic                  accept, push, pop;
  logic                  empty, full;
  logic                  go_add, go_mul;
  logic [CW-1:0]         fcount, occ;
  bf16_resp_t            wr, rd;

  assign accept = req_valid_i && req_ready_o;
  assign pop    = resp_valid_o && resp_ready_i;
  assign push   = tok[LAST].valid && !full;
  assign go_add = tok[0].valid && tok[0].unit == UNIT_ADD;
  assign go_mul = tok[0].valid && tok[0].unit == UNIT_MUL;
  assign op_b   = iss_b ^ {iss_op == MODE_SUB, {(DATA_WIDTH-1){1'b0}}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_op       <= '0;
      iss_a        <= '0;
      iss_b        <= '0;
      ovf_sticky_o <= 1'b0;
      for (int i = 0; i <= LAST; i++) tok[i] <= '0;
    end else begin
      if (accept) begin
        iss_op <= op_i;
        iss_a  <= in1_i;
        iss_b  <= in2_i;
      end
      tok[0] <= '{valid: accept, unit: unit_of(op_i)};
      for (int i = 1; i <= LAST; i++) tok[i] <= tok[i-1];
      // A same-cycle overflow write beats a clear request.
      if (push && wr.overflow) ovf_sticky_o <= 1'b1;
      else if (ovf_clr_i)      ovf_sticky_o <= 1'b0;
    end
  end

  always_comb begin
    add_intf.op1_sign = 1'b0;
    add_intf.op1_exp  = '0;
    add_intf.op1_frac = '0;
    add_intf.op2_sign = 1'b0;
    add_intf.op2_exp  = '0;
    add_intf.op2_frac = '0;
    mul_intf.op1_sign = 1'b0;
    mul_intf.op1_exp  = '0;
    mul_intf.op1_frac = '0;
    mul_intf.op2_sign = 1'b0;
    mul_intf.op2_exp  = '0;
    mul_intf.op2_frac = '0;
    unique case (1'b1)
      go_add: begin
        add_intf.op1_sign = iss_a[DATA_WIDTH-1];
        add_intf.op1_exp  = iss_a[EM -: EXP_WIDTH];
        add_intf.op1_frac = iss_a[FRAC_WIDTH-1:0];
        add_intf.op2_sign = op_b[DATA_WIDTH-1];
        add_intf.op2_exp  = op_b[EM -: EXP_WIDTH];
        add_intf.op2_frac = op_b[FRAC_WIDTH-1:0];
      end
      go_mul: begin
        mul_intf.op1_sign = iss_a[DATA_WIDTH-1];
        mul_intf.op1_exp  = iss_a[EM -: EXP_WIDTH];
        mul_intf.op1_frac = iss_a[FRAC_WIDTH-1:0];
        mul_intf.op2_sign = iss_b[DATA_WIDTH-1];
        mul_intf.op2_exp  = iss_b[EM -: EXP_WIDTH];
        mul_intf.op2_frac = iss_b[FRAC_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    wr = '0;
    unique case (tok[LAST].unit)
      UNIT_ADD: begin
        wr.overflow = add_intf.overflow;
        wr.data = {add_intf.op3_sign, add_intf.op3_exp, add_intf.op3_frac};
      end
      UNIT_MUL: begin
        wr.overflow = mul_intf.overflow;
        wr.data = {mul_intf.op3_sign, mul_intf.op3_exp, mul_intf.op3_frac};
      end
      default: wr.illegal = 1'b1;
    endcase
  end

  // Every token in flight already owns a FIFO slot.
  always_comb begin
    occ = fcount;
    for (int i = 0; i <= LAST; i++) occ = occ + CW'(tok[i].valid);
  end

  assign req_ready_o = !rst_i && (occ < CW'(FIFO_DEPTH));
  assign busy_o      = occ != '0;

  bf16_resp_fifo #(
    .WIDTH ($bits(bf16_resp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wr),
    .pop   (pop),
    .rdata (rd),
    .count (fcount),
    .empty (empty),
    .full  (full)
  );

  assign resp_valid_o = !empty;
  assign out_o        = empty ? '0 : rd.data;
  assign overflow_o   = !empty && rd.overflow;
  assign illegal_o    = !empty && rd.illegal;
endmodule

// File: tb/tb_bf16_op_dispatch.sv
// Directed self-checking bench for bf16_op_dispatch with table-driven
// stand-in add/mul units (UNIT_LAT=0, FIFO_DEPTH=4).
module tb_bf16_op_dispatch;
  import data_type_pkg::*;

  localparam logic [1:0] MODE_ILL = 2'd3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [15:0] in1_i, in2_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [15:0] out_o;
  logic        overflow_o, illegal_o, ovf_sticky_o;
  logic        ovf_clr_i;
  logic        busy_o;

  always #5 clk = ~clk;

  op_intf #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) add_if ();
  op_intf #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) mul_if ();

  bf16_op_dispatch #(
    .EXP_WIDTH(8), .FRAC_WIDTH(7), .UNIT_LAT(0), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .in1_i(in1_i), .in2_i(in2_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .out_o(out_o), .overflow_o(overflow_o), .illegal_o(illegal_o),
    .ovf_sticky_o(ovf_sticky_o), .ovf_clr_i(ovf_clr_i),
    .busy_o(busy_o),
    .add_intf(add_if), .mul_intf(mul_if)
  );

  logic [15:0] add_a, add_b, mul_a, mul_b;
  assign add_a = {add_if.op1_sign, add_if.op1_exp, add_if.op1_frac};
  assign add_b = {add_if.op2_sign, add_if.op2_exp, add_if.op2_frac};
  assign mul_a = {mul_if.op1_sign, mul_if.op1_exp, mul_if.op1_frac};
  assign mul_b = {mul_if.op2_sign, mul_if.op2_exp, mul_if.op2_frac};

  // Hand-computed results {overflow, bf16} for the operand pairs used.
  function automatic logic [16:0] add_ref(input logic [15:0] a, b);
    case ({a, b})
      32'h3F80_4000: return {1'b0, 16'h4040};
      32'h4040_BF80: return {1'b0, 16'h4000};
      32'h4000_4000: return {1'b0, 16'h4080};
      default:       return '0;
    endcase
  endfunction

  function automatic logic [16:0] mul_ref(input logic [15:0] a, b);
    case ({a, b})
      32'h4000_4040: return {1'b0, 16'h40C0};
      32'h4000_4000: return {1'b0, 16'h4080};
      32'h3F80_3F80: return {1'b0, 16'h3F80};
      32'h4040_4040: return {1'b0, 16'h4110};
      32'h7F00_7F00: return {1'b1, 16'h7F80};
      default:       return '0;
    endcase
  endfunction

  assign {add_if.overflow, add_if.op3_sign, add_if.op3_exp, add_if.op3_frac}
    = add_ref(add_a, add_b);
  assign {mul_if.overflow, mul_if.op3_sign, mul_if.op3_exp, mul_if.op3_frac}
    = mul_ref(mul_a, mul_b);

  int          cyc = 0;
  int          acc_cyc;
  int          add_cnt, mul_cnt;
  logic [17:0] rq[$];
  int          rc[$];
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid_o && resp_ready_i) begin
      rq.push_back({illegal_o, overflow_o, out_o});
      rc.push_back(cyc);
    end
    if (add_a != 16'h0 || add_b != 16'h0) add_cnt++;
    if (mul_a != 16'h0 || mul_b != 16'h0) mul_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rq_at(input int i);
    if (i < rq.size()) return 32'(rq[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int rc_at(input int i);
    if (i < rc.size()) return rc[i];
    return -100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rq.delete();
    rc.delete();
    add_cnt = 0;
    mul_cnt = 0;
  endtask

  task automatic offer(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int tries, output bit acc);
    req_valid_i = 1'b1;
    op_i = op;
    in1_i = a;
    in2_i = b;
    acc = 1'b0;
    for (int n = 0; n < tries && !acc; n++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    req_valid_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bit acc;
    offer(op, a, b, 40, acc);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_q(input int n, input string tag);
    for (int k = 0; k < 60 && rq.size() < n; k++) @(negedge clk);
    check(tag, 32'(rq.size() >= n), 32'd1);
  endtask

  logic [1:0]  bp_op [6] = '{MODE_ADD, MODE_MUL, MODE_SUB, MODE_MUL, MODE_MUL, MODE_MUL};
  logic [15:0] bp_a  [6] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4000, 16'h3F80, 16'h4040};
  logic [15:0] bp_b  [6] = '{16'h4000, 16'h4040, 16'h3F80, 16'h4000, 16'h3F80, 16'h4040};
  logic [15:0] bp_r  [6] = '{16'h4040, 16'h40C0, 16'h4000, 16'h4080, 16'h3F80, 16'h4110};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    op_i = '0;
    in1_i = '0;
    in2_i = '0;
    resp_ready_i = 1'b1;
    ovf_clr_i = 1'b0;
    add_cnt = 0;
    mul_cnt = 0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sticky", 32'(ovf_sticky_o), 32'd0);
    check("rst_out", 32'(out_o), 32'd0);
    check("rst_units", 32'(add_a | add_b | mul_a | mul_b), 32'd0);
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready_o), 32'd1);
    tick();

    clear_mon();
    send(MODE_ADD, 16'h3F80, 16'h4000);
    wait_q(1, "add_wait");
    check("add_out", rq_at(0), 32'h0_4040);
    check("add_latency", 32'(rc_at(0) - acc_cyc), 32'd2);
    check("add_mul_idle", 32'(mul_cnt), 32'd0);
    check("add_drive_cycles", 32'(add_cnt), 32'd1);
    repeat (2) tick();
    @(negedge clk);
    check("add_idle_busy", 32'(busy_o), 32'd0);
    tick();

    clear_mon();
    send(MODE_SUB, 16'h4040, 16'h3F80);
    send(MODE_MUL, 16'h4000, 16'h4040);
    wait_q(2, "submul_wait");
    check("sub_out", rq_at(0), 32'h0_4000);
    check("mul_out", rq_at(1), 32'h0_40C0);
    check("submul_consecutive", 32'(rc_at(1) - rc_at(0)), 32'd1);
    repeat (2) tick();

    clear_mon();
    send(MODE_MUL, 16'h7F00, 16'h7F00);
    wait_q(1, "ovf_wait");
    check("ovf_resp", rq_at(0), 32'h1_7F80);
    check("ovf_sticky_set", 32'(ovf_sticky_o), 32'd1);
    tick();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    @(negedge clk);
    check("ovf_clr_alone", 32'(ovf_sticky_o), 32'd0);
    tick();
    send(MODE_MUL, 16'h7F00, 16'h7F00);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    @(negedge clk);
    check("ovf_set_wins", 32'(ovf_sticky_o), 32'd1);
    tick();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    @(negedge clk);
    check("ovf_clr_late", 32'(ovf_sticky_o), 32'd0);
    wait_q(2, "ovf2_wait");
    check("ovf2_resp", rq_at(1), 32'h1_7F80);
    repeat (2) tick();

    clear_mon();
    send(MODE_ADD, 16'h3F80, 16'h4000);
    send(MODE_ILL, 16'h4040, 16'h4040);
    send(MODE_ADD, 16'h4000, 16'h4000);
    wait_q(3, "ill_wait");
    check("ill_first", rq_at(0), 32'h0_4040);
    check("ill_middle", rq_at(1), 32'h2_0000);
    check("ill_last", rq_at(2), 32'h0_4080);
    check("ill_add_cycles", 32'(add_cnt), 32'd2);
    check("ill_mul_idle", 32'(mul_cnt), 32'd0);
    repeat (2) tick();

    clear_mon();
    resp_ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (n_acc == i) begin
        offer(bp_op[i], bp_a[i], bp_b[i], 4, acc);
        if (acc) n_acc++;
      end
    end
    @(negedge clk);
    check("bp_accepted", 32'(n_acc), 32'd4);
    check("bp_ready_low", 32'(req_ready_o), 32'd0);
    check("bp_busy", 32'(busy_o), 32'd1);
    check("bp_head", {14'h0, illegal_o, overflow_o, out_o}, 32'h0_4040);
    repeat (3) tick();
    @(negedge clk);
    check("bp_hold", {14'h0, illegal_o, overflow_o, out_o}, 32'h0_4040);
    tick();
    resp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i >= n_acc) send(bp_op[i], bp_a[i], bp_b[i]);
    end
    wait_q(6, "bp_wait");
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_order%0d", i), rq_at(i), {16'h0, bp_r[i]});
    end
    check("bp_count", 32'(rq.size()), 32'd6);
    @(negedge clk);
    check("bp_drained", 32'(busy_o), 32'd0);
    tick();

    clear_mon();
    resp_ready_i = 1'b0;
    send(MODE_ADD, 16'h3F80, 16'h4000);
    send(MODE_MUL, 16'h7F00, 16'h7F00);
    send(MODE_ADD, 16'h3F80, 16'h4000);
    check("prerst_valid", 32'(resp_valid_o), 32'd1);
    check("prerst_sticky", 32'(ovf_sticky_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_valid", 32'(resp_valid_o), 32'd0);
    check("midrst_out", 32'(out_o), 32'd0);
    check("midrst_flags", {29'h0, overflow_o, illegal_o, ovf_sticky_o}, 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check("midrst_units", 32'(add_a | add_b | mul_a | mul_b), 32'd0);
    tick();
    rst_i = 1'b0;
    resp_ready_i = 1'b1;
    clear_mon();
    @(negedge clk);
    check("postrst_busy", 32'(busy_o), 32'd0);
    check("postrst_valid", 32'(resp_valid_o), 32'd0);
    repeat (3) tick();
    check("postrst_no_stale", 32'(rq.size()), 32'd0);
    send(MODE_ADD, 16'h3F80, 16'h4000);
    wait_q(1, "postrst_wait");
    repeat (3) tick();
    check("postrst_add", rq_at(0), 32'h0_4040);
    check("postrst_count", 32'(rq.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
